branch_sequencer: RTL and testbench

//  Control-unit slice that sequences conditional-branch (brzr/brnz/brpl/brmi) execution.

---
 rtl/branch_sequencer.sv | 109 ++++++++++
 tb/tb_branch_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer.sv
// Conditional-branch sequencer: evaluates CON, forms PC+offset via Y/ALU/Z,
// and loads the PC only when the branch is taken.
module branch_sequencer #(
  parameter logic [4:0] BR_OPCODE = 5'b10010,
  parameter int         IMM_WIDTH = 19
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        hold,
  input  logic        con_out,
  output logic [1:0]  cond,
  output logic        gra,
  output logic        r_out,
  output logic        con_in,
  output logic        pc_out,
  output logic        y_in,
  output logic        c_out,
  output logic [31:0] c_sext,
  output logic        alu_add,
  output logic        z_in,
  output logic        zlow_out,
  output logic        pc_in,
  output logic        busy,
  output logic        done,
  output logic        taken,
  output logic        err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T3   = 3'd1;
  localparam logic [2:0] S_T4   = 3'd2;
  localparam logic [2:0] S_T5   = 3'd3;
  localparam logic [2:0] S_T6   = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [31:0] r_ir_q;
  logic        r_taken;
  logic        r_err;
  logic        w_idle;
  logic        w_is_br;
  logic        w_accept;
  logic        w_bad;
  logic        w_unused;

  assign w_idle   = (r_state == S_IDLE);
  assign w_is_br  = (ir[31:27] == BR_OPCODE);
  assign w_accept = w_idle && start && !hold && w_is_br;
  assign w_bad    = w_idle && start && !hold && !w_is_br;

  always_comb begin
    w_next = r_state;
    if (!hold) begin
      case (r_state)
        S_IDLE:  w_next = w_accept ? S_T3 : S_IDLE;
        S_T3:    w_next = S_T4;
        S_T4:    w_next = S_T5;
        S_T5:    w_next = S_T6;
        S_T6:    w_next = S_FIN;
        S_FIN:   w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // taken is sampled only on a real T3->T4 move, never while stalled in T3
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_ir_q  <= '0;
      r_taken <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_bad;
      if (w_accept) begin
        r_ir_q  <= ir;
        r_taken <= 1'b0;
      end else if (r_state == S_T3 && !hold) begin
        r_taken <= con_out;
      end
    end
  end

  assign gra      = (r_state == S_T3);
  assign r_out    = (r_state == S_T3);
  assign con_in   = (r_state == S_T3);
  assign pc_out   = (r_state == S_T4);
  assign y_in     = (r_state == S_T4);
  assign c_out    = (r_state == S_T5);
  assign alu_add  = (r_state == S_T5);
  assign z_in     = (r_state == S_T5);
  assign zlow_out = (r_state == S_T6);
  assign pc_in    = (r_state == S_T6) && r_taken;
  assign done     = (r_state == S_FIN);
  assign busy     = !w_idle && (r_state != S_FIN);
  assign taken    = r_taken;
  assign err      = r_err;

  assign cond   = r_ir_q[20:19];
  assign c_sext = {{(32-IMM_WIDTH){r_ir_q[IMM_WIDTH-1]}},
                   r_ir_q[IMM_WIDTH-1:0]};

  assign w_unused = ^r_ir_q[31:21];

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: phase-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_branch_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [31:0] ir = '0;
  logic        hold = 1'b0;
  logic        con_out = 1'b0;
  logic [1:0]  cond;
  logic        gra, r_out, con_in, pc_out, y_in, c_out;
  logic [31:0] c_sext;
  logic        alu_add, z_in, zlow_out, pc_in;
  logic        busy, done, taken, err;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b1;

  always #5 clock = ~clock;

  branch_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .ir(ir),
    .hold(hold), .con_out(con_out), .cond(cond), .gra(gra),
    .r_out(r_out), .con_in(con_in), .pc_out(pc_out), .y_in(y_in),
    .c_out(c_out), .c_sext(c_sext), .alu_add(alu_add), .z_in(z_in),
    .zlow_out(zlow_out), .pc_in(pc_in), .busy(busy), .done(done),
    .taken(taken), .err(err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: phase 0=idle, 1..4 = the four work steps, 5 = finish
  int          m_ph    = 0;
  logic [31:0] m_ir    = '0;
  logic        m_taken = 1'b0;
  logic        m_err   = 1'b0;

  always @(posedge clock or posedge clear) begin
    if (clear) begin
      m_ph <= 0; m_ir <= '0; m_taken <= 1'b0; m_err <= 1'b0;
    end else begin
      m_err <= 1'b0;
      if (!hold) begin
        if (m_ph == 0) begin
          if (start) begin
            if (ir[31:27] == 5'b10010) begin
              m_ir <= ir; m_taken <= 1'b0; m_ph <= 1;
            end else begin
              m_err <= 1'b1;
            end
          end
        end else begin
          if (m_ph == 1) m_taken <= con_out;
          m_ph <= (m_ph == 5) ? 0 : m_ph + 1;
        end
      end
    end
  end

  function automatic logic [31:0] sext19(input logic [31:0] v);
    int s;
    s = int'(v[18:0]);
    if (v[18]) s = s - 524288;
    return 32'(s);
  endfunction

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("gra",      gra,      m_ph == 1);
      chk("r_out",    r_out,    m_ph == 1);
      chk("con_in",   con_in,   m_ph == 1);
      chk("pc_out",   pc_out,   m_ph == 2);
      chk("y_in",     y_in,     m_ph == 2);
      chk("c_out",    c_out,    m_ph == 3);
      chk("alu_add",  alu_add,  m_ph == 3);
      chk("z_in",     z_in,     m_ph == 3);
      chk("zlow_out", zlow_out, m_ph == 4);
      chk("pc_in",    pc_in,    (m_ph == 4) && m_taken);
      chk("busy",     busy,     (m_ph >= 1) && (m_ph <= 4));
      chk("done",     done,     m_ph == 5);
      chk("err",      err,      m_err);
      chk("taken",    taken,    m_taken);
      chk("cond",     cond,     m_ir[20:19]);
      chk("c_sext",   c_sext,   sext19(m_ir));
      chk("bus_onehot",
          $countones({r_out, pc_out, c_out, zlow_out}) <= 1, 1);
      chk("done_err_excl", done && err, 0);
    end
  end

  task automatic run_br(input string nm, input logic [31:0] iv,
                        input logic con, input int hold_n,
                        input int exp_done, input logic exp_taken,
                        input logic [31:0] exp_sext,
                        input logic [1:0] exp_cond, input bit mid_start);
    int dk, npc, hl;
    logic pcin;
    logic [31:0] sx;
    logic [1:0] cd;
    @(negedge clock); #1;
    start = 1'b1; ir = iv; con_out = con; hold = 1'b0;
    dk = 0; npc = 0; pcin = 1'b0; sx = '0; cd = '0; hl = hold_n;
    for (int k = 1; k <= 20 && dk == 0; k++) begin
      @(negedge clock);
      if (c_out) sx = c_sext;
      if (pc_out) npc++;
      if (pc_in) pcin = 1'b1;
      if (gra) cd = cond;
      if (done) dk = k;
      #1;
      start = 1'b0; con_out = con; hold = 1'b0;
      if (pc_out && hl > 0) begin
        hold = 1'b1; hl--; con_out = ~con;
      end
      if (mid_start && c_out) begin
        start = 1'b1; ir = 32'h9000_0008;
      end
    end
    chk({nm, "_done_cycle"}, dk, exp_done);
    chk({nm, "_taken"}, taken, exp_taken);
    chk({nm, "_pc_in"}, pcin, exp_taken);
    chk({nm, "_sext"}, sx, exp_sext);
    chk({nm, "_cond"}, cd, exp_cond);
    chk({nm, "_pc_out_cycles"}, npc, hold_n + 1);
    @(negedge clock);
    chk({nm, "_idle_busy"}, busy, 0);
    chk({nm, "_idle_sext"}, c_sext, exp_sext);
  endtask

  initial begin
    int guard;
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_sext", c_sext, 0);
    chk("rst_taken", taken, 0);
    #1 clear = 1'b0;

    run_br("brzr_taken", 32'h9000_0004, 1'b1, 0, 5, 1'b1,
           32'h0000_0004, 2'b00, 1'b0);
    run_br("brnz_not", 32'h9008_0010, 1'b0, 0, 5, 1'b0,
           32'h0000_0010, 2'b01, 1'b0);
    run_br("neg_off", 32'h9017_FFFC, 1'b1, 0, 5, 1'b1,
           32'hFFFF_FFFC, 2'b10, 1'b0);
    run_br("hold_t4", 32'h9000_0004, 1'b1, 3, 8, 1'b1,
           32'h0000_0004, 2'b00, 1'b0);
    run_br("mid_start", 32'h9018_0020, 1'b0, 0, 5, 1'b0,
           32'h0000_0020, 2'b11, 1'b1);

    #1 start = 1'b1; ir = 32'h1000_0000;
    @(negedge clock);
    chk("illegal_err", err, 1);
    chk("illegal_busy", busy, 0);
    #1 start = 1'b0;
    @(negedge clock);
    chk("illegal_err_pulse", err, 0);
    chk("illegal_ir_kept", c_sext, 32'h0000_0020);

    #1 start = 1'b1; ir = 32'h9000_0004; con_out = 1'b1;
    guard = 0;
    do begin
      @(negedge clock); #1 start = 1'b0; guard++;
    end while (!z_in && guard < 20);
    chk("clr_reach_t5", z_in, 1);
    clear = 1'b1;
    @(negedge clock);
    chk("clr_busy", busy, 0);
    chk("clr_z_in", z_in, 0);
    chk("clr_taken", taken, 0);
    chk("clr_pc_in", pc_in, 0);
    #1 clear = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clock); #1;
      clear   = ($urandom_range(0, 199) == 0);
      start   = ($urandom_range(0, 2) == 0);
      ir      = $urandom;
      if ($urandom_range(0, 9) < 7) ir[31:27] = 5'b10010;
      hold    = ($urandom_range(0, 4) == 0);
      con_out = $urandom_range(0, 1) == 1;
    end
    @(negedge clock); #1;
    clear = 1'b0; start = 1'b0; hold = 1'b0;
    repeat (10) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
